// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the iterative radix-4 Booth multiplier
//   state_t       - FSM states IDLE / BUSY / DONE
//   booth_digit_t - encoded Booth digit: neg (subtract), one (x1), two (x2)
//   booth_iter()  - Booth digits needed for a given operand width
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Operands are extended by two bits, so WIDTH+2 bits need WIDTH/2+1 digits
    function automatic int booth_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// booth_r4_digit_enc: radix-4 Booth recoder, triplet {q[2i+1], q[2i], q[2i-1]} to digit
//   triplet - multiplier bits, lsb is the bit below the digit position
//   digit   - {neg, one, two}; zero digit has all fields clear
module booth_r4_digit_enc
    import mult_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit
);

    // 111 is -0, so neg is suppressed there to keep the zero digit canonical
    always_comb begin
        digit.neg = triplet[2] & ~(triplet[1] & triplet[0]);
        digit.one = triplet[1] ^ triplet[0];
        digit.two = (triplet == 3'b011) | (triplet == 3'b100);
    end

endmodule

// File: rtl/booth_radix4_iter.sv
// booth_radix4_iter: iterative radix-4 Booth multiplier, one digit per clock
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - operand handshake; a, b, signed_mode sampled on accept
//   out_valid/out_ready - result handshake; product held until accepted
//   product             - exact 2*WIDTH-bit product
//   busy                - digits are being retired
module booth_radix4_iter
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int ITER = booth_iter(WIDTH);
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER);

    if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_radix4_iter: WIDTH must be even and >= 4");
    end

    state_t            state;
    logic [AW-1:0]     mcand;
    logic [AW-1:0]     acc;
    logic [WIDTH+2:0]  mplr;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     a_ext;
    logic [WIDTH+1:0]  b_ext;
    logic [AW-1:0]     pp;
    logic [AW-1:0]     acc_next;
    booth_digit_t      dig;

    // mplr keeps q[-1] in bit 0 and shifts right two per digit, so the
    // current triplet is always mplr[2:0]; mcand shifts left in step
    booth_r4_digit_enc u_enc (
        .triplet (mplr[2:0]),
        .digit   (dig)
    );

    always_comb begin
        a_ext    = {{(AW-WIDTH){signed_mode & a[WIDTH-1]}}, a};
        b_ext    = {{2{signed_mode & b[WIDTH-1]}}, b};
        pp       = dig.two ? {mcand[AW-2:0], 1'b0} : dig.one ? mcand : '0;
        acc_next = dig.neg ? acc - pp : acc + pp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mplr    <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mcand <= a_ext;
                    mplr  <= {b_ext, 1'b0};
                    acc   <= '0;
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    acc   <= acc_next;
                    mcand <= mcand << 2;
                    mplr  <= mplr >> 2;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        product <= acc_next[2*WIDTH-1:0];
                        state   <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_booth_radix4_iter.sv
// tb_booth_radix4_iter: self-checking bench for booth_radix4_iter at WIDTH 8, 16 and 32
module tb_booth_radix4_iter;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        m;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] exp;
        int          t;
    } sb_t;

    logic clk = 0;
    logic rst_n = 0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic        iv8 = 0, ir8, m8 = 0, ov8, or8 = 1, bz8, pov8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;
    logic        iv16 = 0, ir16, m16 = 0, ov16, or16 = 1, bz16, pov16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] p16;
    logic        iv32 = 0, ir32, m32 = 0, ov32, or32 = 1, bz32, pov32 = 0;
    logic [31:0] a32 = 0, b32 = 0;
    logic [63:0] p32;

    sb_t q8[$], q16[$], q32[$];
    sb_t e8, e16, e32;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_radix4_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .signed_mode(m8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(bz8)
    );
    booth_radix4_iter #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .signed_mode(m16), .out_valid(ov16), .out_ready(or16), .product(p16), .busy(bz16)
    );
    booth_radix4_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .signed_mode(m32), .out_valid(ov32), .out_ready(or32), .product(p32), .busy(bz32)
    );

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input int w, input logic m);
        logic signed [63:0] sx, sy;
        logic [63:0] p;
        sx = {32'b0, x} << (64 - w);
        sy = {32'b0, y} << (64 - w);
        sx = m ? sx >>> (64 - w) : sx >> (64 - w);
        sy = m ? sy >>> (64 - w) : sy >> (64 - w);
        p  = sx * sy;
        return p & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    task automatic drv8(input logic [7:0] x, input logic [7:0] y, input logic m,
                        input logic [63:0] exp);
        int n = 0;
        @(negedge clk);
        a8 = x; b8 = y; m8 = m; iv8 = 1;
        while (!ir8 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin chk("w8 in_ready timeout", ir8, 1); iv8 = 0; return; end
        @(posedge clk); #1;
        iv8 = 0;
        q8.push_back('{exp, cyc});
    endtask

    task automatic drv16(input logic [15:0] x, input logic [15:0] y, input logic m);
        int n = 0;
        @(negedge clk);
        a16 = x; b16 = y; m16 = m; iv16 = 1;
        while (!ir16 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin chk("w16 in_ready timeout", ir16, 1); iv16 = 0; return; end
        @(posedge clk); #1;
        iv16 = 0;
        q16.push_back('{ref_prod(x, y, 16, m), cyc});
    endtask

    task automatic drv32(input logic [31:0] x, input logic [31:0] y, input logic m);
        int n = 0;
        @(negedge clk);
        a32 = x; b32 = y; m32 = m; iv32 = 1;
        while (!ir32 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin chk("w32 in_ready timeout", ir32, 1); iv32 = 0; return; end
        @(posedge clk); #1;
        iv32 = 0;
        q32.push_back('{ref_prod(x, y, 32, m), cyc});
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q8.size() != 0 || q16.size() != 0 || q32.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain w8", q8.size(), 0);
        chk("drain w16", q16.size(), 0);
        chk("drain w32", q32.size(), 0);
    endtask

    // Scoreboards: compare on the first cycle of each out_valid, including latency
    always @(negedge clk) begin
        if (ov8 && !pov8) begin
            if (q8.size() == 0) chk("w8 spurious out_valid", ov8, 0);
            else begin
                e8 = q8.pop_front();
                chk("w8 product", p8, e8.exp);
                chk("w8 latency", cyc - e8.t, 5);
            end
        end
        pov8 <= ov8;
    end

    always @(negedge clk) begin
        if (ov16 && !pov16) begin
            if (q16.size() == 0) chk("w16 spurious out_valid", ov16, 0);
            else begin
                e16 = q16.pop_front();
                chk("w16 product", p16, e16.exp);
                chk("w16 latency", cyc - e16.t, 9);
            end
        end
        pov16 <= ov16;
    end

    always @(negedge clk) begin
        if (ov32 && !pov32) begin
            if (q32.size() == 0) chk("w32 spurious out_valid", ov32, 0);
            else begin
                e32 = q32.pop_front();
                chk("w32 product", p32, e32.exp);
                chk("w32 latency", cyc - e32.t, 17);
            end
        end
        pov32 <= ov32;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int n;
        vecs[0]  = '{8'hFB, 8'h0A, 1'b1, 16'hFFCE};
        vecs[1]  = '{8'h00, 8'h0F, 1'b1, 16'h0000};
        vecs[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[3]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[4]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[5]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[7]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vecs[8]  = '{8'h03, 8'hFD, 1'b0, 16'h02F7};
        vecs[9]  = '{8'hFD, 8'h03, 1'b1, 16'hFFF7};
        vecs[10] = '{8'h01, 8'h80, 1'b1, 16'hFF80};
        vecs[11] = '{8'h80, 8'h01, 1'b0, 16'h0080};

        repeat (3) @(negedge clk);
        chk("reset in_ready", ir8, 1);
        chk("reset out_valid", ov8, 0);
        chk("reset busy", bz8, 0);
        chk("reset product", p8, 0);
        chk("reset w16 in_ready", ir16, 1);
        chk("reset w32 out_valid", ov32, 0);
        rst_n = 1;

        for (int i = 0; i < 12; i++) drv8(vecs[i].a, vecs[i].b, vecs[i].m, {48'b0, vecs[i].exp});
        wait_drain();

        // Operand pins scribbled while iterating must not disturb the latched job
        drv8(8'hFF, 8'hFF, 1'b0, 64'hFE01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m8 = ~m8; a8 = 8'(i * 37 + 1); b8 = 8'(i * 91 + 5);
        end
        wait_drain();

        // Backpressure: result held, pending input refused until after the handshake
        or8 = 0;
        drv8(8'h12, 8'h34, 1'b0, 64'h03A8);
        n = 0;
        while (!ov8 && n < 50) begin @(negedge clk); n++; end
        chk("bp out_valid reached", ov8, 1);
        a8 = 8'h03; b8 = 8'h05; m8 = 0; iv8 = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp product hold", p8, 16'h03A8);
            chk("bp in_ready", ir8, 0);
            chk("bp out_valid", ov8, 1);
            chk("bp busy", bz8, 0);
        end
        or8 = 1;
        @(negedge clk);
        chk("bp after handshake out_valid", ov8, 0);
        chk("bp after handshake in_ready", ir8, 1);
        chk("bp after handshake busy", bz8, 0);
        @(posedge clk); #1;
        iv8 = 0;
        q8.push_back('{64'h000F, cyc});
        @(negedge clk);
        chk("bp pending accepted", bz8, 1);
        wait_drain();

        // Reset during digit 2 aborts the job with no result
        drv8(8'h55, 8'h66, 1'b1, 64'h21DE);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 0;
        q8.delete();
        #1;
        chk("abort in_ready", ir8, 1);
        chk("abort out_valid", ov8, 0);
        chk("abort busy", bz8, 0);
        chk("abort product", p8, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort no out_valid", ov8, 0);
        end
        drv8(8'h55, 8'h66, 1'b1, 64'h21DE);
        wait_drain();

        fork
            begin
                logic [7:0] x, y;
                for (int m = 0; m < 2; m++)
                    for (int i = 0; i < 1000; i++) begin
                        x = 8'($urandom); y = 8'($urandom);
                        drv8(x, y, m[0], ref_prod({24'b0, x}, {24'b0, y}, 8, m[0]));
                    end
            end
            begin
                logic [15:0] x, y;
                for (int m = 0; m < 2; m++)
                    for (int i = 0; i < 1000; i++) begin
                        x = 16'($urandom); y = 16'($urandom);
                        drv16(x, y, m[0]);
                    end
            end
            begin
                logic [31:0] x, y;
                for (int m = 0; m < 2; m++)
                    for (int i = 0; i < 1000; i++) begin
                        x = $urandom; y = $urandom;
                        if (i < 4) begin
                            x = i[0] ? 32'h8000_0000 : 32'hFFFF_FFFF;
                            y = i[1] ? 32'h8000_0000 : 32'hFFFF_FFFF;
                        end
                        drv32(x, y, m[0]);
                    end
            end
        join
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
